// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU datapath.
//   WIDTH            datapath / address width
//   RESET_PC_DEFAULT default first fetch address after reset (even)
//   INSTR_BYTES      instruction size in bytes (PC increment)
//   fetch_state_e    fetch FSM state encoding
package cpu_pkg;

  localparam int WIDTH = 16;
  localparam logic [WIDTH-1:0] RESET_PC_DEFAULT = 16'h0000;
  localparam int INSTR_BYTES = 2;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational redirect target generator, shared by fetch and decode.
// Ports:
//   pc            in   address of the current instruction
//   branch_take   in   PC-relative branch request
//   branch_offset in   sign-extended word offset
//   jump_en       in   absolute jump request (wins over branch)
//   jump_addr     in   absolute jump address (bit0 ignored)
//   pc_plus2      out  pc + 2
//   redirect      out  any redirect requested this cycle
//   target        out  selected redirect target, always even
module branch_target_calc
  import cpu_pkg::*;
#(
  parameter int WIDTH_P = WIDTH
) (
  input  logic [WIDTH_P-1:0] pc,
  input  logic               branch_take,
  input  logic [WIDTH_P-1:0] branch_offset,
  input  logic               jump_en,
  input  logic [WIDTH_P-1:0] jump_addr,
  output logic [WIDTH_P-1:0] pc_plus2,
  output logic               redirect,
  output logic [WIDTH_P-1:0] target
);

  logic [WIDTH_P-1:0] offset_bytes;
  logic               unused_bits;

  // Word offset to byte offset; the offset MSB falls off the top.
  assign offset_bytes = {branch_offset[WIDTH_P-2:0], 1'b0};
  assign pc_plus2     = pc + WIDTH_P'(INSTR_BYTES);
  assign redirect     = jump_en | branch_take;
  assign target       = jump_en ? {jump_addr[WIDTH_P-1:1], 1'b0}
                                : pc_plus2 + offset_bytes;

  assign unused_bits  = &{1'b0, branch_offset[WIDTH_P-1], jump_addr[0]};

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: holds the PC, issues word fetches over a
// req/ack handshake and latches returned instructions for decode.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   stall          blocks issue of a new fetch (outstanding one completes)
//   branch_take    PC-relative redirect relative to pc
//   branch_offset  sign-extended word offset
//   jump_en        absolute redirect (priority over branch)
//   jump_addr      absolute target
//   fetch_req      memory request, held until fetch_ack
//   fetch_addr     request address, always even, stable while requesting
//   fetch_ack      memory returns fetch_data this cycle
//   fetch_data     instruction word
//   instr          latched instruction
//   instr_valid    one-cycle pulse when instr/pc update
//   pc             address of instr
//   pc_plus2       pc + 2 (combinational)
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH_P  = WIDTH,
  parameter logic [WIDTH_P-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_take,
  input  logic [WIDTH_P-1:0] branch_offset,
  input  logic               jump_en,
  input  logic [WIDTH_P-1:0] jump_addr,
  output logic               fetch_req,
  output logic [WIDTH_P-1:0] fetch_addr,
  input  logic               fetch_ack,
  input  logic [WIDTH_P-1:0] fetch_data,
  output logic [WIDTH_P-1:0] instr,
  output logic               instr_valid,
  output logic [WIDTH_P-1:0] pc,
  output logic [WIDTH_P-1:0] pc_plus2
);

  localparam logic [WIDTH_P-1:0] START_PC = {RESET_PC[WIDTH_P-1:1], 1'b0};

  fetch_state_e       state_q, state_d;
  logic [WIDTH_P-1:0] fetch_addr_q, fetch_addr_d;
  logic [WIDTH_P-1:0] next_addr_q, next_addr_d;
  logic [WIDTH_P-1:0] instr_q, instr_d;
  logic [WIDTH_P-1:0] pc_q, pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic               discard_q, discard_d;

  logic               redirect;
  logic [WIDTH_P-1:0] target;

  branch_target_calc #(
    .WIDTH_P(WIDTH_P)
  ) u_target (
    .pc           (pc_q),
    .branch_take  (branch_take),
    .branch_offset(branch_offset),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .pc_plus2     (pc_plus2),
    .redirect     (redirect),
    .target       (target)
  );

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    next_addr_d   = next_addr_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    instr_valid_d = 1'b0;
    discard_d     = discard_q;

    unique case (state_q)
      IDLE: begin
        // A redirect seen while idle is used by the very fetch issued now.
        if (redirect) begin
          next_addr_d = target;
        end
        if (!stall) begin
          state_d      = REQ;
          fetch_addr_d = next_addr_d;
        end
      end

      REQ: begin
        if (fetch_ack) begin
          if (redirect || discard_q) begin
            // Word belongs to the abandoned path: drop it.
            discard_d = 1'b0;
            if (redirect) begin
              next_addr_d = target;
            end
          end else begin
            instr_d       = fetch_data;
            pc_d          = fetch_addr_q;
            instr_valid_d = 1'b1;
            next_addr_d   = fetch_addr_q + WIDTH_P'(INSTR_BYTES);
          end
          if (stall) begin
            state_d = IDLE;
          end else begin
            fetch_addr_d = next_addr_d;
          end
        end else if (redirect) begin
          // fetch_addr must stay stable; remember to drop the in-flight word.
          next_addr_d = target;
          discard_d   = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_addr_q  <= START_PC;
      next_addr_q   <= START_PC;
      instr_q       <= '0;
      pc_q          <= START_PC;
      instr_valid_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      next_addr_q   <= next_addr_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      discard_q     <= discard_d;
    end
  end

  assign fetch_req   = (state_q == REQ);
  assign fetch_addr  = fetch_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;

endmodule
